// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues one req/ack bus transaction per load/store,
// stalls the pipeline until it completes, and aborts unacknowledged accesses with a watchdog.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] count;
  logic       access;

  assign access = mem_read | mem_write;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = access;
        if (access) state_next = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_ack || (count == LAST)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // The pipeline must not see a stall while the controller is held in reset.
    if (!rst) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= 8'd0;
      rdata     <= 32'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (access) begin
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_we    <= mem_write;
            bus_req   <= 1'b1;
            count     <= 8'd0;
          end
        end
        WAIT: begin
          // An acknowledge arriving on the last watchdog cycle still completes normally.
          if (bus_ack) begin
            if (!bus_we) rdata <= bus_rdata;
            bus_req <= 1'b0;
          end else if (count == LAST) begin
            if (!bus_we) rdata <= ERR_RDATA;
            bus_err <= 1'b1;
            bus_req <= 1'b0;
          end else if (count != 8'hFF) begin
            count <= count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; inputs change on the falling edge
// and outputs are sampled 1 time unit later, well away from the rising edge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int compared   = 0;
  int mismatched = 0;

  mem_access_ctrl #(.TIMEOUT(16), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task test_reset;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #2 mem_read = 1'b1;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bus_req: got %b want 0", bus_req); end
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bus_err: got %b want 0", bus_err); end
    compared++; if (rdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    compared++; if (bus_addr !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_bus_addr: got %h want 0", bus_addr); end
    mem_read = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  task test_single_read;
    int stall_cycles;
    stall_cycles = 0;
    mem_read = 1'b1; mem_addr = 32'h100;
    #1 if (stall === 1'b1) stall_cycles++;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    #1 if (stall === 1'b1) stall_cycles++;
    compared++; if (bus_req !== 1'b1) begin mismatched++; $display("[TB] FAIL read_bus_req: got %b want 1", bus_req); end
    compared++; if (bus_we !== 1'b0) begin mismatched++; $display("[TB] FAIL read_bus_we: got %b want 0", bus_we); end
    compared++; if (bus_addr !== 32'h100) begin mismatched++; $display("[TB] FAIL read_bus_addr: got %h want 00000100", bus_addr); end
    @(negedge clk); bus_ack = 1'b0;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL read_done_stall: got %b want 0", stall); end
    compared++; if (rdata !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL read_rdata: got %h want 12345678", rdata); end
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("[TB] FAIL read_req_drop: got %b want 0", bus_req); end
    compared++; if (stall_cycles !== 2) begin mismatched++; $display("[TB] FAIL read_stall_len: got %0d want 2", stall_cycles); end
    @(negedge clk); mem_read = 1'b0;
    #1;
    compared++; if (stall !== 1'b0 || bus_req !== 1'b0) begin mismatched++; $display("[TB] FAIL read_idle: got stall=%b req=%b want 0/0", stall, bus_req); end
  endtask

  task test_write;
    int   stall_cycles;
    logic held_bad;
    stall_cycles = 0; held_bad = 1'b0;
    mem_write = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hA5A5_A5A5;
    #1 if (stall === 1'b1) stall_cycles++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus_ack = (i == 4);
      #1 if (stall === 1'b1) stall_cycles++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h40 || bus_wdata !== 32'hA5A5_A5A5) held_bad = 1'b1;
    end
    compared++; if (held_bad !== 1'b0) begin mismatched++; $display("[TB] FAIL write_held: got unstable bus want stable"); end
    @(negedge clk); bus_ack = 1'b0;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL write_done_stall: got %b want 0", stall); end
    compared++; if (rdata !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL write_rdata_kept: got %h want 12345678", rdata); end
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("[TB] FAIL write_req_drop: got %b want 0", bus_req); end
    compared++; if (stall_cycles !== 6) begin mismatched++; $display("[TB] FAIL write_stall_len: got %0d want 6", stall_cycles); end
    @(negedge clk); mem_write = 1'b0;
  endtask

  task test_collision;
    logic held_bad;
    held_bad = 1'b0;
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); bus_ack = (i == 15); bus_rdata = 32'h7777_7777;
      #1 if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_wdata !== 32'hCAFE_F00D) held_bad = 1'b1;
    end
    compared++; if (held_bad !== 1'b0) begin mismatched++; $display("[TB] FAIL both_as_write: got read or dropped req want write"); end
    @(negedge clk); bus_ack = 1'b0;
    #1;
    compared++; if (bus_err !== 1'b0) begin mismatched++; $display("[TB] FAIL ack_beats_timeout: got bus_err=%b want 0", bus_err); end
    compared++; if (rdata !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL both_rdata_kept: got %h want 12345678", rdata); end
    compared++; if (bus_req !== 1'b0 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL both_done: got req=%b stall=%b want 0/0", bus_req, stall); end
    @(negedge clk); mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task test_back_to_back;
    mem_read = 1'b1; mem_addr = 32'h200;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    @(negedge clk); bus_ack = 1'b0;
    #1;
    compared++; if (rdata !== 32'h1111_1111 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_first: got rdata=%h stall=%b want 11111111/0", rdata, stall); end
    @(negedge clk); mem_addr = 32'h204;
    #1;
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_no_reissue: got req=%b want 0", bus_req); end
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_idle_stall: got %b want 1", stall); end
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
    #1;
    compared++; if (bus_req !== 1'b1 || bus_addr !== 32'h204) begin mismatched++; $display("[TB] FAIL b2b_second_req: got req=%b addr=%h want 1/00000204", bus_req, bus_addr); end
    @(negedge clk); bus_ack = 1'b0;
    #1;
    compared++; if (rdata !== 32'h2222_2222) begin mismatched++; $display("[TB] FAIL b2b_second_rdata: got %h want 22222222", rdata); end
    @(negedge clk); mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h3333_3333;
    @(negedge clk); bus_ack = 1'b0;
    #1;
    compared++; if (rdata !== 32'h2222_2222 || bus_req !== 1'b0 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_ack_ignored: got rdata=%h req=%b stall=%b want 22222222/0/0", rdata, bus_req, stall); end
  endtask

  task test_timeout;
    int   stall_cycles;
    logic held_bad;
    stall_cycles = 0; held_bad = 1'b0;
    mem_read = 1'b1; mem_addr = 32'h80;
    #1 if (stall === 1'b1) stall_cycles++;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1 if (stall === 1'b1) stall_cycles++;
      if (bus_req !== 1'b1) held_bad = 1'b1;
    end
    compared++; if (held_bad !== 1'b0 || bus_err !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_early: got early drop or err=%b want req held/err 0", bus_err); end
    @(negedge clk);
    #1;
    compared++; if (bus_req !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_req_drop: got %b want 0", bus_req); end
    compared++; if (bus_err !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_err: got %b want 1", bus_err); end
    compared++; if (rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL timeout_rdata: got %h want deadbeef", rdata); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_release: got %b want 0", stall); end
    compared++; if (stall_cycles !== 17) begin mismatched++; $display("[TB] FAIL timeout_stall_len: got %0d want 17", stall_cycles); end
    @(negedge clk); mem_read = 1'b0;
    @(negedge clk);
    #1;
    compared++; if (bus_err !== 1'b1) begin mismatched++; $display("[TB] FAIL err_sticky: got %b want 1", bus_err); end
  endtask

  task test_reset_mid_access;
    mem_read = 1'b1; mem_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    #1;
    compared++; if (bus_req !== 1'b1) begin mismatched++; $display("[TB] FAIL pre_reset_req: got %b want 1", bus_req); end
    #2 rst = 1'b0;
    #1;
    compared++; if (stall !== 1'b0 || bus_req !== 1'b0 || bus_err !== 1'b0) begin mismatched++; $display("[TB] FAIL async_reset: got stall=%b req=%b err=%b want 0/0/0", stall, bus_req, bus_err); end
    @(negedge clk); rst = 1'b1; mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
    @(negedge clk); bus_ack = 1'b0;
    #1;
    compared++; if (rdata !== 32'd0 || bus_req !== 1'b0 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL late_ack_ignored: got rdata=%h req=%b stall=%b want 0/0/0", rdata, bus_req, stall); end
    mem_read = 1'b1; mem_addr = 32'h500;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    #1;
    compared++; if (bus_req !== 1'b1 || bus_addr !== 32'h500) begin mismatched++; $display("[TB] FAIL post_reset_req: got req=%b addr=%h want 1/00000500", bus_req, bus_addr); end
    @(negedge clk); bus_ack = 1'b0;
    #1;
    compared++; if (rdata !== 32'h5555_AAAA || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_read: got rdata=%h stall=%b want 5555aaaa/0", rdata, stall); end
    @(negedge clk); mem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_collision();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
